// File: rtl/ps2_sensor_pkg.sv
// ps2_sensor_pkg
// Shared definitions for the PS/2 sensor command decoder:
//   - scancode constants (prefix bytes and every recognised make code)
//   - decoder FSM state encoding
//   - key-class encoding produced by the key lookup table
//   - temperature setpoints bound to the numeric keys, in degrees C
package ps2_sensor_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Temperature keys (top-row digits 1..0)
  localparam logic [7:0] SC_T0    = 8'h16;
  localparam logic [7:0] SC_T1    = 8'h1E;
  localparam logic [7:0] SC_T2    = 8'h26;
  localparam logic [7:0] SC_T3    = 8'h25;
  localparam logic [7:0] SC_T4    = 8'h2E;
  localparam logic [7:0] SC_T5    = 8'h36;
  localparam logic [7:0] SC_T6    = 8'h3D;
  localparam logic [7:0] SC_T7    = 8'h3E;
  localparam logic [7:0] SC_T8    = 8'h46;
  localparam logic [7:0] SC_T9    = 8'h45;

  // Smoke key and channel-select keys (F1..F4)
  localparam logic [7:0] SC_SMOKE = 8'h33;
  localparam logic [7:0] SC_CH0   = 8'h05;
  localparam logic [7:0] SC_CH1   = 8'h06;
  localparam logic [7:0] SC_CH2   = 8'h04;
  localparam logic [7:0] SC_CH3   = 8'h0C;

  // Setpoints bound to SC_T0..SC_T9
  localparam logic [7:0] TEMP_0   = 8'd10;
  localparam logic [7:0] TEMP_1   = 8'd15;
  localparam logic [7:0] TEMP_2   = 8'd20;
  localparam logic [7:0] TEMP_3   = 8'd25;
  localparam logic [7:0] TEMP_4   = 8'd27;
  localparam logic [7:0] TEMP_5   = 8'd30;
  localparam logic [7:0] TEMP_6   = 8'd32;
  localparam logic [7:0] TEMP_7   = 8'd35;
  localparam logic [7:0] TEMP_8   = 8'd39;
  localparam logic [7:0] TEMP_9   = 8'd41;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    KEY_NONE  = 2'd0,
    KEY_TEMP  = 2'd1,
    KEY_SMOKE = 2'd2,
    KEY_CHSEL = 2'd3
  } key_class_e;

endpackage

// File: rtl/ps2_sensor_cmd_decoder_lut.sv
// ps2_key_lut
// Purely combinational classification of one make code.
// Ports:
//   code       in   8  scancode byte
//   key_class  out  2  key_class_e value (NONE, TEMP, SMOKE, CHSEL)
//   temp_val   out  8  setpoint for TEMP keys, 0 otherwise
//   ch_idx     out  2  channel number for CHSEL keys, 0 otherwise
module ps2_key_lut
  import ps2_sensor_pkg::*;
(
  input  logic [7:0] code,
  output logic [1:0] key_class,
  output logic [7:0] temp_val,
  output logic [1:0] ch_idx
);

  always_comb begin
    key_class = KEY_NONE;
    temp_val  = 8'd0;
    ch_idx    = 2'd0;
    case (code)
      SC_T0:    begin key_class = KEY_TEMP;  temp_val = TEMP_0; end
      SC_T1:    begin key_class = KEY_TEMP;  temp_val = TEMP_1; end
      SC_T2:    begin key_class = KEY_TEMP;  temp_val = TEMP_2; end
      SC_T3:    begin key_class = KEY_TEMP;  temp_val = TEMP_3; end
      SC_T4:    begin key_class = KEY_TEMP;  temp_val = TEMP_4; end
      SC_T5:    begin key_class = KEY_TEMP;  temp_val = TEMP_5; end
      SC_T6:    begin key_class = KEY_TEMP;  temp_val = TEMP_6; end
      SC_T7:    begin key_class = KEY_TEMP;  temp_val = TEMP_7; end
      SC_T8:    begin key_class = KEY_TEMP;  temp_val = TEMP_8; end
      SC_T9:    begin key_class = KEY_TEMP;  temp_val = TEMP_9; end
      SC_SMOKE: key_class = KEY_SMOKE;
      SC_CH0:   begin key_class = KEY_CHSEL; ch_idx = 2'd0; end
      SC_CH1:   begin key_class = KEY_CHSEL; ch_idx = 2'd1; end
      SC_CH2:   begin key_class = KEY_CHSEL; ch_idx = 2'd2; end
      SC_CH3:   begin key_class = KEY_CHSEL; ch_idx = 2'd3; end
      default:  key_class = KEY_NONE;
    endcase
  end

endmodule

// File: rtl/ps2_sensor_cmd_decoder.sv
// ps2_sensor_cmd_decoder
// Turns PS/2 scancode bytes into per-channel temperature setpoints and
// smoke flags. Tracks F0 (break) and E0 (extended) prefixes, abandons a
// dangling prefix after TMO_CYC cycles, and strobes upd_vld for every
// temperature or smoke write.
// Optional feature: define REPEAT_FILTER_EN to drop typematic repeats
// (a make code identical to the previous make, with no break between).
// Ports:
//   clk       in   1            rising-edge clock
//   rst_n     in   1            synchronous active-low reset
//   code_in   in   8            scancode byte
//   code_vld  in   1            code_in valid strobe
//   temp_out  out  N_CH*DATA_W  setpoints, channel k at [k*DATA_W +: DATA_W]
//   smoke     out  N_CH         per-channel smoke flags
//   ch_sel    out  2            selected channel
//   upd_vld   out  1            pulse: a channel was written
//   upd_ch    out  2            channel written, valid with upd_vld
//   unk       out  1            pulse: unrecognised make code
module ps2_sensor_cmd_decoder
  import ps2_sensor_pkg::*;
#(
  parameter int DATA_W  = 7,
  parameter int N_CH    = 2,
  parameter int TMO_CYC = 50000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               code_in,
  input  logic                     code_vld,
  output logic [N_CH*DATA_W-1:0]   temp_out,
  output logic [N_CH-1:0]          smoke,
  output logic [1:0]               ch_sel,
  output logic                     upd_vld,
  output logic [1:0]               upd_ch,
  output logic                     unk
);

  localparam int CNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [N_CH*DATA_W-1:0]   temp_q, temp_d;
  logic [N_CH-1:0]          smoke_q, smoke_d;
  logic [1:0]               ch_sel_q, ch_sel_d;
  logic                     upd_vld_q, upd_vld_d;
  logic [1:0]               upd_ch_q, upd_ch_d;
  logic                     unk_q, unk_d;

  logic [1:0]               lut_class;
  logic [7:0]               lut_temp;
  logic [1:0]               lut_ch;
  logic                     repeat_hit;

  ps2_key_lut u_lut (
    .code      (code_in),
    .key_class (lut_class),
    .temp_val  (lut_temp),
    .ch_idx    (lut_ch)
  );

`ifdef REPEAT_FILTER_EN
  logic [7:0] last_make_q, last_make_d;
  assign repeat_hit = (code_in == last_make_q);
`else
  assign repeat_hit = 1'b0;
`endif

  // Next-state logic. The counter only runs while a prefix is pending;
  // a byte on the expiry cycle wins over the timeout.
  always_comb begin
    state_d   = state_q;
    temp_d    = temp_q;
    smoke_d   = smoke_q;
    ch_sel_d  = ch_sel_q;
    upd_ch_d  = upd_ch_q;
    upd_vld_d = 1'b0;
    unk_d     = 1'b0;
`ifdef REPEAT_FILTER_EN
    last_make_d = last_make_q;
`endif
    cnt_d = (state_q == ST_IDLE) ? '0 : cnt_q + 1'b1;

    if (code_vld) begin
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (code_in == SC_BRK) begin
            state_d = ST_BRK;
          end else if (code_in == SC_EXT) begin
            state_d = ST_EXT;
          end else if (!repeat_hit) begin
`ifdef REPEAT_FILTER_EN
            last_make_d = code_in;
`endif
            case (lut_class)
              KEY_TEMP: begin
                for (int k = 0; k < N_CH; k++) begin
                  if (ch_sel_q == 2'(k)) temp_d[k*DATA_W +: DATA_W] = DATA_W'(lut_temp);
                end
                upd_vld_d = 1'b1;
                upd_ch_d  = ch_sel_q;
              end
              KEY_SMOKE: begin
                for (int k = 0; k < N_CH; k++) begin
                  if (ch_sel_q == 2'(k)) smoke_d[k] = 1'b1;
                end
                upd_vld_d = 1'b1;
                upd_ch_d  = ch_sel_q;
              end
              // Channels beyond N_CH are silently ignored.
              KEY_CHSEL: begin
                if (int'(lut_ch) < N_CH) ch_sel_d = lut_ch;
              end
              default: unk_d = 1'b1;
            endcase
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
`ifdef REPEAT_FILTER_EN
          last_make_d = 8'h00;
`endif
          if (code_in == SC_SMOKE) begin
            for (int k = 0; k < N_CH; k++) begin
              if (ch_sel_q == 2'(k)) smoke_d[k] = 1'b0;
            end
            upd_vld_d = 1'b1;
            upd_ch_d  = ch_sel_q;
          end
        end
        ST_EXT: begin
          state_d = (code_in == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
`ifdef REPEAT_FILTER_EN
          last_make_d = 8'h00;
`endif
        end
      endcase
    end else if ((state_q != ST_IDLE) && (cnt_q == CNT_LAST)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      temp_q    <= '0;
      smoke_q   <= '0;
      ch_sel_q  <= 2'd0;
      upd_vld_q <= 1'b0;
      upd_ch_q  <= 2'd0;
      unk_q     <= 1'b0;
`ifdef REPEAT_FILTER_EN
      last_make_q <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      temp_q    <= temp_d;
      smoke_q   <= smoke_d;
      ch_sel_q  <= ch_sel_d;
      upd_vld_q <= upd_vld_d;
      upd_ch_q  <= upd_ch_d;
      unk_q     <= unk_d;
`ifdef REPEAT_FILTER_EN
      last_make_q <= last_make_d;
`endif
    end
  end

  assign temp_out = temp_q;
  assign smoke    = smoke_q;
  assign ch_sel   = ch_sel_q;
  assign upd_vld  = upd_vld_q;
  assign upd_ch   = upd_ch_q;
  assign unk      = unk_q;

endmodule

// File: tb/tb_ps2_sensor_cmd_decoder.sv
// tb_ps2_sensor_cmd_decoder
// Directed bench for ps2_sensor_cmd_decoder (N_CH=2, DATA_W=7, short
// TMO_CYC so the prefix timeout is reachable quickly). Register state is
// compared against a small expected model kept here; upd_vld/unk pulses
// are matched in order against a queue of expected events.
// Honours REPEAT_FILTER_EN the same way the design does.
module tb_ps2_sensor_cmd_decoder;

  localparam int DATA_W  = 7;
  localparam int N_CH    = 2;
  localparam int TMO_CYC = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [7:0]             code_in;
  logic                   code_vld;
  logic [N_CH*DATA_W-1:0] temp_out;
  logic [N_CH-1:0]        smoke;
  logic [1:0]             ch_sel;
  logic                   upd_vld;
  logic [1:0]             upd_ch;
  logic                   unk;

  typedef struct packed {
    logic       upd;
    logic       unk;
    logic [1:0] ch;
  } evt_t;

  evt_t           expQ[$];
  int             nChecks = 0;
  int             nPass   = 0;
  int             expTemp[N_CH];
  logic [N_CH-1:0] expSmoke;
  logic [1:0]     expCh;

  ps2_sensor_cmd_decoder #(
    .DATA_W  (DATA_W),
    .N_CH    (N_CH),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .code_in  (code_in),
    .code_vld (code_vld),
    .temp_out (temp_out),
    .smoke    (smoke),
    .ch_sel   (ch_sel),
    .upd_vld  (upd_vld),
    .upd_ch   (upd_ch),
    .unk      (unk)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) nPass++;
    else $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
  endtask

  task automatic checkState(input string tag);
    for (int k = 0; k < N_CH; k++)
      checkOutput($sformatf("%s_temp%0d", tag, k), 32'(temp_out[k*DATA_W +: DATA_W]),
                  32'(expTemp[k]));
    checkOutput({tag, "_smoke"}, 32'(smoke), 32'(expSmoke));
    checkOutput({tag, "_ch_sel"}, 32'(ch_sel), 32'(expCh));
  endtask

  // One byte with a one-cycle gap after it.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    code_in  = b;
    code_vld = 1'b1;
    @(negedge clk);
    code_vld = 1'b0;
    code_in  = 8'h00;
  endtask

  // Same byte on n consecutive cycles.
  task automatic applyBurst(input logic [7:0] b, input int n);
    @(negedge clk);
    code_in  = b;
    code_vld = 1'b1;
    repeat (n) @(negedge clk);
    code_vld = 1'b0;
    code_in  = 8'h00;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pushUpd(input logic [1:0] ch);
    evt_t e;
    e.upd = 1'b1;
    e.unk = 1'b0;
    e.ch  = ch;
    expQ.push_back(e);
  endtask

  task automatic pushUnk();
    evt_t e;
    e.upd = 1'b0;
    e.unk = 1'b1;
    e.ch  = 2'd0;
    expQ.push_back(e);
  endtask

  // Every pulse must match the oldest expected event; a pulse with nothing
  // queued is compared against an all-zero event and so reports a failure.
  always @(negedge clk) begin
    if (upd_vld || unk) begin
      evt_t obs;
      evt_t exp;
      obs.upd = upd_vld;
      obs.unk = unk;
      obs.ch  = upd_vld ? upd_ch : 2'd0;
      if (expQ.size() > 0) exp = expQ.pop_front();
      else exp = '0;
      checkOutput("event", 32'(obs), 32'(exp));
    end
  end

  initial begin
    rst_n    = 1'b0;
    code_in  = 8'h00;
    code_vld = 1'b0;
    for (int k = 0; k < N_CH; k++) expTemp[k] = 0;
    expSmoke = '0;
    expCh    = 2'd0;

    // Reset values
    waitCycles(3);
    checkState("reset");
    checkOutput("reset_upd_vld", 32'(upd_vld), 32'd0);
    checkOutput("reset_unk", 32'(unk), 32'd0);
    rst_n = 1'b1;

    // Temp and smoke on channel 0
    $display("[TB] step 1: temp/smoke on ch0");
    pushUpd(2'd0);
    applyStimulus(8'h26);
    expTemp[0] = 20;
    checkState("t1_temp");
    pushUpd(2'd0);
    applyStimulus(8'h33);
    expSmoke = 2'b01;
    checkState("t1_smoke");

    // Channel 1 select, temp, smoke set and break-clear
    $display("[TB] step 2: channel 1");
    applyStimulus(8'h06);
    expCh = 2'd1;
    checkState("t2_sel");
    pushUpd(2'd1);
    applyStimulus(8'h45);
    expTemp[1] = 41;
    checkState("t2_temp");
    pushUpd(2'd1);
    applyStimulus(8'h33);
    expSmoke = 2'b11;
    checkState("t2_smoke_set");
    pushUpd(2'd1);
    applyStimulus(8'hF0);
    applyStimulus(8'h33);
    expSmoke = 2'b01;
    checkState("t2_smoke_clr");

    // Follow-up byte on the expiry cycle is still a break
    $display("[TB] step 3: prefix timeout");
    pushUpd(2'd1);
    applyStimulus(8'h33);
    expSmoke = 2'b11;
    applyStimulus(8'hF0);
    waitCycles(TMO_CYC - 2);
    pushUpd(2'd1);
    applyStimulus(8'h33);
    expSmoke = 2'b01;
    checkState("t3_coincide");
    // One cycle later the prefix has expired and the byte is a make
    applyStimulus(8'hF0);
    waitCycles(TMO_CYC - 1);
    checkState("t3_expired_quiet");
    pushUpd(2'd1);
    applyStimulus(8'h3E);
    expTemp[1] = 35;
    checkState("t3_make");

    // Extended break is ignored; unknown make pulses unk
    $display("[TB] step 4: extended and unknown");
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'h16);
    checkState("t4_ext");
    pushUnk();
    applyStimulus(8'h1C);
    checkState("t4_unk");

    // Out-of-range channel; reset discards a pending prefix
    $display("[TB] step 5: channel range and reset");
    applyStimulus(8'h05);
    expCh = 2'd0;
    applyStimulus(8'h0C);
    checkState("t5_ch3");
    applyStimulus(8'hF0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N_CH; k++) expTemp[k] = 0;
    expSmoke = '0;
    expCh    = 2'd0;
    checkState("t5_reset");
    pushUpd(2'd0);
    applyStimulus(8'h16);
    expTemp[0] = 10;
    checkState("t5_make");

    // Typematic repeats, back-to-back
    $display("[TB] step 6: repeats");
    pushUpd(2'd0);
`ifndef REPEAT_FILTER_EN
    pushUpd(2'd0);
    pushUpd(2'd0);
`endif
    applyBurst(8'h1E, 3);
    waitCycles(2);
    expTemp[0] = 15;
    checkState("t6_repeat");

    waitCycles(3);
    checkOutput("events_drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
